// File: rtl/stream_fifo.sv
// Single-clock stream FIFO with status flags, sticky error flags and selectable
// first-word-fall-through or registered read.
module stream_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 4096,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    if (WIDTH < 1) begin : g_width_check
        $error("stream_fifo: WIDTH must be at least 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("stream_fifo: DEPTH must be a power of two >= 4");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_th_check
        $error("stream_fifo: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc;
    logic          wr_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept a write.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Setting takes priority over a simultaneous clear.
        if (wr_en && full && !rd_acc) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end

        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown straight from the array; forced to zero while empty.
        assign rd_valid = !empty;
        assign rd_data  = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr_q];
                end
            end
        end

        assign rd_valid = rd_valid_q;
        assign rd_data  = rd_data_q;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed scoreboard bench driving a FWFT and a registered-read FIFO with shared stimulus.
module tb_stream_fifo;

    localparam int W   = 8;
    localparam int D   = 8;
    localparam int AF  = 6;
    localparam int AE  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic         clr_err = 1'b0;

    logic [W-1:0] f_rd_data, s_rd_data;
    logic         f_rd_valid, s_rd_valid;
    logic         f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic         s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [3:0]   f_count, s_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb [$];
    bit           ovf_m;
    bit           unf_m;
    bit           s_valid_m;
    logic [W-1:0] s_data_m;

    always #5 clk = ~clk;

    stream_fifo #(
        .WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    stream_fifo #(
        .WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int n;
        n = sb.size();
        check("f_count", f_count, n);
        check("f_empty", f_empty, n == 0);
        check("f_full", f_full, n == D);
        check("f_almost_full", f_afull, n >= AF);
        check("f_almost_empty", f_aempty, n <= AE);
        check("f_overflow", f_ovf, ovf_m);
        check("f_underflow", f_unf, unf_m);
        check("f_rd_valid", f_rd_valid, n > 0);
        check("f_rd_data", f_rd_data, (n > 0) ? sb[0] : 8'h00);
        check("s_count", s_count, n);
        check("s_full", s_full, n == D);
        check("s_empty", s_empty, n == 0);
        check("s_overflow", s_ovf, ovf_m);
        check("s_underflow", s_unf, unf_m);
        check("s_rd_valid", s_rd_valid, s_valid_m);
        check("s_rd_data", s_rd_data, s_data_m);
    endtask

    task automatic model_reset();
        sb.delete();
        ovf_m     = 1'b0;
        unf_m     = 1'b0;
        s_valid_m = 1'b0;
        s_data_m  = '0;
    endtask

    // One clock of stimulus; the model advances at the edge and status is checked #1 later.
    task automatic step(input bit we, input logic [W-1:0] wd, input bit re, input bit ce);
        bit ra;
        bit wa;
        int n;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        #1;
        if (re && sb.size() > 0) check("f_head_at_pop", f_rd_data, sb[0]);
        @(posedge clk);
        n  = sb.size();
        ra = re && (n > 0);
        wa = we && ((n < D) || ra);
        s_valid_m = ra;
        if (ra) s_data_m = sb.pop_front();
        if (wa) sb.push_back(wd);
        if (we && n == D && !ra) ovf_m = 1'b1;
        else if (ce) ovf_m = 1'b0;
        if (re && n == 0) unf_m = 1'b1;
        else if (ce) unf_m = 1'b0;
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        check_status();
    endtask

    initial begin
        // Power-on reset.
        #1 rst = 1'b0;
        #2;
        model_reset();
        check_status();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word through an empty FIFO.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full, overflow attempt, drain in order, clear the error.
        for (int i = 0; i < D; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full FIFO streaming across pointer wrap.
        for (int i = 0; i < D; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h18 + i), 1'b1, 1'b0);
        for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read/write on an empty FIFO; then read and clear together.
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Registered-read behaviour: pulse and hold.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_status();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 128, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4096, number of entries (power of two, >=4).
REQ-003 SHALL have parameter FWFT, default 1, read mode (1 = first-word-fall-through, 0 = standard registered read).
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4, almost-full threshold in words.
REQ-005 SHALL have parameter AEMPTY_TH, default 4, almost-empty threshold in words.
REQ-006 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  WIDTH  write word.
REQ-010 SHALL have port rd_en  input  1  read request (FWFT: pop the head word).
REQ-011 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 SHALL have port rd_data  output  WIDTH  read word.
REQ-013 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  stored word count, 0..DEPTH.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write SHALL be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle); word stored at wr_ptr, wr_ptr increments.
REQ-018 Read SHALL be accepted when rd_en=1 and empty=0; rd_ptr increments.
REQ-019 Pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no gap.
REQ-020 count SHALL be +1 on write-only, -1 on read-only, unchanged on both or neither; never outside 0..DEPTH.
REQ-021 empty SHALL equal (count==0), full (count==DEPTH), almost_full (count>=AFULL_TH), almost_empty (count<=AEMPTY_TH); all derived from registered count, so each changes at the edge where count changes.
REQ-022 Simultaneous rd_en and wr_en when full: both accepted, count stays DEPTH, no overflow.
REQ-023 Simultaneous rd_en and wr_en when empty: write accepted, read rejected, underflow set, count becomes 1.
REQ-024 FWFT=1: rd_valid SHALL equal !empty and rd_data SHALL present the head word whenever rd_valid=1; a word written into an empty FIFO appears on rd_data with rd_valid=1 at the same edge empty deasserts (1-cycle write-to-data latency); rd_en with rd_valid=1 pops and the next word (if any) is presented the following cycle.
REQ-025 FWFT=0: an accepted read SHALL load rd_data with the head word at that edge and assert rd_valid for exactly one cycle; rd_data SHALL hold its value otherwise.
REQ-026 overflow SHALL set when wr_en=1, full=1 and no read is accepted; the write is dropped and no state changes.
REQ-027 underflow SHALL set when rd_en=1 and empty=1; rd_data unchanged, rd_valid stays 0.
REQ-028 overflow/underflow SHALL stay set until clr_err=1; a set condition in the same cycle as clr_err wins.
REQ-029 The block SHALL fail elaboration unless DEPTH is a power of two >=4 and 0<=AEMPTY_TH<AFULL_TH<=DEPTH.

Reset
REQ-030 rst=0 SHALL immediately clear wr_ptr, rd_ptr, count, rd_data (all zero), rd_valid, full, almost_full, overflow, underflow, and set empty=1, almost_empty=1.
REQ-031 Reset mid-operation SHALL discard all stored words; after rst release the first accepted write behaves as into an empty FIFO.
REQ-032 Memory contents need not be reset.

Verification (DEPTH=8, WIDTH=8, AFULL_TH=6, AEMPTY_TH=2)
REQ-033 FWFT=1, write 0xA5 to empty FIFO -> next cycle rd_valid=1, rd_data=0xA5, empty=0, count=1; rd_en one cycle -> empty=1, count=0.
REQ-034 Write 0x00..0x07 -> almost_full rises at count=6, full at count=8; 9th write -> overflow=1, count=8; read all -> 0x00..0x07 in order; clr_err -> overflow=0.
REQ-035 Full FIFO, rd_en=wr_en=1 for 20 cycles with incrementing data -> count stays 8, no errors, output sequence continuous across pointer wrap.
REQ-036 Empty FIFO, rd_en=wr_en=1 one cycle -> underflow=1, count=1, written word readable next.
REQ-037 FWFT=0, write 0x11,0x22, then rd_en one cycle -> rd_data=0x11 with single-cycle rd_valid pulse; rd_data holds 0x11 until next read returns 0x22.
REQ-038 Assert rst=0 with count=5 mid-stream -> all outputs at reset values asynchronously; after release, write 0x3C then read -> 0x3C.
